// File: rtl/mux_pkg.sv
// Shared constants and types for the 2-to-1 selection datapath and its round-robin front end.
package mux_pkg;

    localparam logic SEL_A         = 1'b0;
    localparam logic SEL_B         = 1'b1;
    localparam int   DEFAULT_WIDTH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/mux_2to1.sv
// Single-bit 2-to-1 multiplexer; sel = 0 passes a, sel = 1 passes b.
module mux_2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/rr_merge_2to1.sv
// Round-robin merge of two valid/ready streams into a single-entry registered output.
module rr_merge_2to1
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel
);

    state_e             state_q, state_d;
    logic               prio_q,  prio_d;
    logic               sel_q,   sel_d;
    logic [WIDTH-1:0]   y_data_q, y_data_d;

    logic               load;
    logic               grant;
    logic               g;
    logic [WIDTH-1:0]   mux_y;

    assign load  = (state_q == EMPTY) | y_ready;
    assign grant = a_valid | b_valid;

    // With both sources valid the pointer decides; otherwise the lone requester wins.
    always_comb begin
        g = SEL_A;
        if (a_valid && b_valid) begin
            g = prio_q;
        end else if (b_valid) begin
            g = SEL_B;
        end
    end

    // Readys are forced low while reset is held, even though load is high when EMPTY.
    assign a_ready = rst_n & load & a_valid & (g == SEL_A);
    assign b_ready = rst_n & load & b_valid & (g == SEL_B);

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_2to1 u_mux (
            .a   (a_data[i]),
            .b   (b_data[i]),
            .sel (g),
            .y   (mux_y[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        sel_d    = sel_q;
        y_data_d = y_data_q;
        if (load) begin
            if (grant) begin
                state_d  = FULL;
                y_data_d = mux_y;
                sel_d    = g;
                prio_d   = ~g;
            end else begin
                state_d  = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            prio_q   <= SEL_A;
            sel_q    <= SEL_A;
            y_data_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            sel_q    <= sel_d;
            y_data_q <= y_data_d;
        end
    end

    assign y_valid = (state_q == FULL);
    assign y_data  = y_data_q;
    assign sel     = sel_q;

endmodule
